// File: rtl/nv_nvdla_sdp_nrdma_eg_ro_writer_pkg.sv
// Shared SDP NRDMA egress definitions: writer state encoding, atom mask bit
// positions and the layout of the DMA read-response payload.
package nv_nvdla_sdp_nrdma_eg_ro_writer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } eg_state_t;

    localparam int MASK_LO = 0;
    localparam int MASK_HI = 1;

    // Response payload is {mask[1:0], data[2*aw-1:0]}.
    localparam int PD_DATA_LSB = 0;
    localparam int PD_MASK_W   = 2;

    function automatic int pd_mask_lsb(input int aw);
        return 2 * aw;
    endfunction

endpackage

// File: rtl/nv_nvdla_sdp_nrdma_eg_ro_writer.sv
// Splits masked 2-atom DMA read-response beats into single atoms and pushes
// them into the ro data FIFO, counting atoms per layer between load and done.
module nv_nvdla_sdp_nrdma_eg_ro_writer
    import nv_nvdla_sdp_nrdma_eg_ro_writer_pkg::*;
#(
    parameter int AW = 256,
    parameter int CW = 13
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rst,
    input  logic              op_load,
    input  logic [CW-1:0]     reg2dp_total_atoms,
    input  logic              dma_rd_rsp_pvld,
    output logic              dma_rd_rsp_prdy,
    input  logic [2*AW+1:0]   dma_rd_rsp_pd,
    output logic              rod_wr_pvld,
    input  logic              rod_wr_prdy,
    output logic [AW-1:0]     rod_wr_pd,
    output logic              eg_busy,
    output logic              eg_done
);

    localparam int MASK_LSB = pd_mask_lsb(AW);

    eg_state_t          state;
    eg_state_t          state_nxt;
    logic [CW-1:0]      remain;
    logic [2*AW-1:0]    hold_data_p1;
    logic [1:0]         pending_p1;
    logic               hold_vld_p1;
    logic               done_p1;

    logic [1:0]         rsp_mask;
    logic [2*AW-1:0]    rsp_data;
    logic               sel_hi;
    logic [1:0]         pending_clr;
    logic               push;
    logic               final_push;
    logic               last_push;
    logic               accept;

    assign rsp_mask = dma_rd_rsp_pd[MASK_LSB +: PD_MASK_W];
    assign rsp_data = dma_rd_rsp_pd[PD_DATA_LSB +: 2*AW];

    // Low atom goes first; the high atom is sent once the low bit is gone.
    assign sel_hi      = ~pending_p1[MASK_LO];
    assign pending_clr = sel_hi ? (pending_p1 & ~(2'b1 << MASK_HI))
                                : (pending_p1 & ~(2'b1 << MASK_LO));

    assign push       = hold_vld_p1 & rod_wr_prdy;
    assign final_push = push & (remain == '0);
    assign last_push  = push & ((pending_clr == 2'b00) | final_push);

    // The layer-ending push never takes a new beat, so nothing is lost on
    // the way back to IDLE.
    assign dma_rd_rsp_prdy = (state == RUN) & (~hold_vld_p1 | (last_push & ~final_push));
    assign accept          = dma_rd_rsp_pvld & dma_rd_rsp_prdy;

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (op_load)    state_nxt = RUN;
            RUN:  if (final_push) state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            remain <= '0;
        end else if ((state == IDLE) && op_load) begin
            remain <= reg2dp_total_atoms;
        end else if (push && !final_push) begin
            remain <= remain - 1'b1;
        end
    end

    // Stage p1: hold register presenting one atom per cycle to the FIFO.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            hold_data_p1 <= '0;
            pending_p1   <= 2'b00;
            hold_vld_p1  <= 1'b0;
        end else if (accept) begin
            hold_data_p1 <= rsp_data;
            pending_p1   <= rsp_mask;
            hold_vld_p1  <= |rsp_mask;
        end else if (push) begin
            pending_p1   <= final_push ? 2'b00 : pending_clr;
            hold_vld_p1  <= ~final_push & (|pending_clr);
        end
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            done_p1 <= 1'b0;
        end else begin
            done_p1 <= final_push;
        end
    end

    assign rod_wr_pvld = hold_vld_p1;
    assign rod_wr_pd   = sel_hi ? hold_data_p1[AW +: AW] : hold_data_p1[0 +: AW];
    assign eg_busy     = (state == RUN);
    assign eg_done     = done_p1;

endmodule

// File: tb/tb_nv_nvdla_sdp_nrdma_eg_ro_writer.sv
// Directed bench for the NRDMA egress ro writer: beat splitting, mask
// handling, stalls, layer termination and asynchronous reset.
module tb_nv_nvdla_sdp_nrdma_eg_ro_writer;

    localparam int AW = 256;
    localparam int CW = 13;

    logic              clk;
    logic              rst;
    logic              op_load;
    logic [CW-1:0]     total;
    logic              rsp_pvld;
    logic              rsp_prdy;
    logic [2*AW+1:0]   rsp_pd;
    logic              rod_pvld;
    logic              rod_prdy;
    logic [AW-1:0]     rod_pd;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_errors = 0;

    nv_nvdla_sdp_nrdma_eg_ro_writer #(.AW(AW), .CW(CW)) dut (
        .nvdla_core_clk     (clk),
        .nvdla_core_rst     (rst),
        .op_load            (op_load),
        .reg2dp_total_atoms (total),
        .dma_rd_rsp_pvld    (rsp_pvld),
        .dma_rd_rsp_prdy    (rsp_prdy),
        .dma_rd_rsp_pd      (rsp_pd),
        .rod_wr_pvld        (rod_pvld),
        .rod_wr_prdy        (rod_prdy),
        .rod_wr_pd          (rod_pd),
        .eg_busy            (busy),
        .eg_done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [AW-1:0] atom(input int k);
        logic [31:0] w;
        w = 32'hC0DE_0000 | k;
        return {8{w}};
    endfunction

    function automatic logic [2*AW+1:0] beat(input int b, input logic [1:0] m);
        return {m, atom(2*b+1), atom(2*b)};
    endfunction

    task automatic chk(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nx();
        @(negedge clk);
    endtask

    task automatic load(input int t);
        op_load = 1'b1;
        total   = CW'(t);
        nx();
        op_load = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        op_load  = 1'b0;
        total    = '0;
        rsp_pvld = 1'b0;
        rsp_pd   = '0;
        rod_prdy = 1'b1;
        #3;
        chk("rst_pvld", rod_pvld, 0);
        chk("rst_pd",   rod_pd,   0);
        chk("rst_prdy", rsp_prdy, 0);
        chk("rst_busy", busy,     0);
        chk("rst_done", done,     0);
        nx();
        rst = 1'b0;
        nx();

        // Two full beats, total=3: lo0 hi0 lo1 hi1 back to back.
        load(3);
        chk("t1_busy", busy, 1);
        chk("t1_prdy0", rsp_prdy, 1);
        rsp_pvld = 1'b1; rsp_pd = beat(0, 2'b11);
        nx();
        chk("t1_pvld_lo0", rod_pvld, 1);
        chk("t1_lo0", rod_pd, atom(0));
        chk("t1_prdy_lo0", rsp_prdy, 0);
        rsp_pd = beat(1, 2'b11);
        nx();
        chk("t1_hi0", rod_pd, atom(1));
        chk("t1_prdy_hi0", rsp_prdy, 1);
        nx();
        rsp_pvld = 1'b0;
        chk("t1_lo1", rod_pd, atom(2));
        chk("t1_prdy_lo1", rsp_prdy, 0);
        nx();
        chk("t1_pvld_hi1", rod_pvld, 1);
        chk("t1_hi1", rod_pd, atom(3));
        chk("t1_done_early", done, 0);
        nx();
        chk("t1_done", done, 1);
        chk("t1_busy_end", busy, 0);
        chk("t1_pvld_end", rod_pvld, 0);
        nx();
        chk("t1_done_pulse", done, 0);

        // Masks 10, 00, 01 with total=1.
        load(1);
        rsp_pvld = 1'b1; rsp_pd = beat(2, 2'b10);
        nx();
        chk("t2_hi2", rod_pd, atom(5));
        chk("t2_prdy_hi2", rsp_prdy, 1);
        rsp_pd = beat(3, 2'b00);
        nx();
        chk("t2_nopush", rod_pvld, 0);
        chk("t2_prdy_empty", rsp_prdy, 1);
        rsp_pd = beat(4, 2'b01);
        nx();
        rsp_pvld = 1'b0;
        chk("t2_pvld_lo4", rod_pvld, 1);
        chk("t2_lo4", rod_pd, atom(8));
        nx();
        chk("t2_done", done, 1);
        chk("t2_busy", busy, 0);

        // total=0: only the low atom of an 11 beat goes out; then IDLE ignores pvld.
        load(0);
        rsp_pvld = 1'b1; rsp_pd = beat(5, 2'b11);
        nx();
        chk("t3_lo5", rod_pd, atom(10));
        chk("t3_prdy_final", rsp_prdy, 0);
        rsp_pd = beat(6, 2'b11);
        nx();
        chk("t3_done", done, 1);
        chk("t3_hi_dropped", rod_pvld, 0);
        chk("t3_idle_prdy", rsp_prdy, 0);
        for (int i = 0; i < 3; i++) begin
            nx();
            chk("t3_idle_prdy_hold", rsp_prdy, 0);
            chk("t3_idle_pvld", rod_pvld, 0);
        end
        rsp_pvld = 1'b0;

        // Stall with an atom pending, total=2.
        load(2);
        rsp_pvld = 1'b1; rsp_pd = beat(6, 2'b11);
        nx();
        chk("t4_lo6", rod_pd, atom(12));
        rod_prdy = 1'b0;
        rsp_pd = beat(7, 2'b01);
        for (int i = 0; i < 5; i++) begin
            nx();
            chk("t4_stall_pvld", rod_pvld, 1);
            chk("t4_stall_pd", rod_pd, atom(12));
            chk("t4_stall_prdy", rsp_prdy, 0);
        end
        rod_prdy = 1'b1;
        nx();
        chk("t4_hi6", rod_pd, atom(13));
        chk("t4_prdy_hi6", rsp_prdy, 1);
        nx();
        rsp_pvld = 1'b0;
        chk("t4_lo7", rod_pd, atom(14));
        nx();
        chk("t4_done", done, 1);

        // Asynchronous reset with two atoms pending at remain=5.
        load(5);
        rsp_pvld = 1'b1; rsp_pd = beat(8, 2'b11);
        rod_prdy = 1'b0;
        nx();
        rsp_pvld = 1'b0;
        chk("t5_pending", rod_pvld, 1);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_pvld", rod_pvld, 0);
        chk("t5_rst_pd",   rod_pd,   0);
        chk("t5_rst_prdy", rsp_prdy, 0);
        chk("t5_rst_busy", busy,     0);
        nx();
        rst = 1'b0;
        rod_prdy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            nx();
            chk("t5_no_done", done, 0);
        end
        load(0);
        chk("t5_prdy_new", rsp_prdy, 1);
        rsp_pvld = 1'b1; rsp_pd = beat(9, 2'b01);
        nx();
        rsp_pvld = 1'b0;
        chk("t5_lo9", rod_pd, atom(18));
        nx();
        chk("t5_done", done, 1);

        // op_load during RUN must not reload the counter.
        load(1);
        rsp_pvld = 1'b1; rsp_pd = beat(10, 2'b11);
        nx();
        rsp_pvld = 1'b0;
        chk("t6_lo10", rod_pd, atom(20));
        op_load = 1'b1; total = CW'(7);
        nx();
        op_load = 1'b0;
        chk("t6_hi10", rod_pd, atom(21));
        chk("t6_final_prdy", rsp_prdy, 0);
        nx();
        chk("t6_done", done, 1);
        chk("t6_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
